// File: rtl/threefish_pkg.sv
// Shared Threefish-512 definitions: word geometry, the MIX rotation table,
// and small helpers used by the MIX, permutation and key-schedule stages.
package threefish_pkg;

  localparam int WORD_W    = 64;
  localparam int NUM_WORDS = 8;
  localparam int STATE_W   = WORD_W * NUM_WORDS;

  // Rotation amounts R[d mod 8][pair]
  localparam logic [5:0] ROT512 [8][4] = '{
    '{6'd46, 6'd36, 6'd19, 6'd37},
    '{6'd33, 6'd27, 6'd14, 6'd42},
    '{6'd17, 6'd49, 6'd36, 6'd39},
    '{6'd44, 6'd9,  6'd54, 6'd56},
    '{6'd39, 6'd30, 6'd34, 6'd24},
    '{6'd13, 6'd50, 6'd10, 6'd17},
    '{6'd25, 6'd29, 6'd39, 6'd43},
    '{6'd8,  6'd35, 6'd56, 6'd22}
  };

  // Word 0 lives in the MSBs; this returns the LSB position of word i.
  function automatic int word_lsb(input int i);
    return STATE_W - WORD_W * (i + 1);
  endfunction

  function automatic logic [WORD_W-1:0] get_word(input logic [STATE_W-1:0] s, input int i);
    return s[word_lsb(i) +: WORD_W];
  endfunction

  function automatic logic [WORD_W-1:0] rotl64(input logic [WORD_W-1:0] x, input logic [5:0] r);
    return (x << r) | (x >> (7'd64 - {1'b0, r}));
  endfunction

endpackage

// File: rtl/threefish_mix.sv
// Combinational Threefish MIX of one word pair:
//   y0 = x0 + x1 (mod 2^64), y1 = rotl(x1, rot) ^ y0.
module threefish_mix
  import threefish_pkg::*;
(
  input  logic [WORD_W-1:0] x0_i,
  input  logic [WORD_W-1:0] x1_i,
  input  logic [5:0]        rot_i,
  output logic [WORD_W-1:0] y0_o,
  output logic [WORD_W-1:0] y1_o
);

  assign y0_o = x0_i + x1_i;
  assign y1_o = rotl64(x1_i, rot_i) ^ y0_o;

endmodule

// File: rtl/threefish_mix_stage.sv
// Registered MIX layer of one Threefish-512 round with valid/ready on both
// sides. Default build: one register stage, latency 1.
// Define THREEFISH_MIX_PIPE2_EN for a two-stage version (sum/rotate, then
// xor), latency 2, same results and full throughput.
module threefish_mix_stage
  import threefish_pkg::*;
#(
  parameter int ROUND_W = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inValid,
  output logic               inReady,
  input  logic [STATE_W-1:0] inData,
  input  logic [ROUND_W-1:0] inRound,
  output logic               outValid,
  input  logic               outReady,
  output logic [STATE_W-1:0] outData,
  output logic [ROUND_W-1:0] outRound
);

`ifndef THREEFISH_MIX_PIPE2_EN

  logic [STATE_W-1:0] mix_res;
  logic               valid_q, valid_d;
  logic [STATE_W-1:0] data_q, data_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               accept;

  for (genvar j = 0; j < 4; j++) begin : g_mix
    logic [WORD_W-1:0] y0, y1;
    threefish_mix u_mix (
      .x0_i  (get_word(inData, 2 * j)),
      .x1_i  (get_word(inData, 2 * j + 1)),
      .rot_i (ROT512[inRound[2:0]][j]),
      .y0_o  (y0),
      .y1_o  (y1)
    );
    assign mix_res[STATE_W - 1 - 2 * WORD_W * j -: WORD_W]      = y0;
    assign mix_res[STATE_W - 1 - WORD_W * (2 * j + 1) -: WORD_W] = y1;
  end

  assign inReady = !valid_q || outReady;
  assign accept  = inValid && inReady;

  // Next state: load on accept, drain when consumed, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    round_d = round_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = mix_res;
      round_d = inRound;
    end else if (outReady) begin
      valid_d = 1'b0;
    end
  end

  // Output register; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      round_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      round_q <= round_d;
    end
  end

  assign outValid = valid_q;
  assign outData  = data_q;
  assign outRound = round_q;

`else

  logic               valid_a_q, valid_a_d;
  logic [WORD_W-1:0]  sum_q [4];
  logic [WORD_W-1:0]  sum_d [4];
  logic [WORD_W-1:0]  rot_q [4];
  logic [WORD_W-1:0]  rot_d [4];
  logic [ROUND_W-1:0] round_a_q, round_a_d;
  logic               valid_b_q, valid_b_d;
  logic [STATE_W-1:0] data_b_q, data_b_d;
  logic [ROUND_W-1:0] round_b_q, round_b_d;
  logic [STATE_W-1:0] xor_res;
  logic               ready_a, accept_a, move_ab;

  assign ready_a  = !valid_b_q || outReady;
  assign inReady  = !valid_a_q || ready_a;
  assign accept_a = inValid && inReady;
  assign move_ab  = valid_a_q && ready_a;

  // Stage A next state: pair sums and rotated odd words.
  always_comb begin
    valid_a_d = valid_a_q;
    round_a_d = round_a_q;
    sum_d     = sum_q;
    rot_d     = rot_q;
    if (accept_a) begin
      valid_a_d = 1'b1;
      round_a_d = inRound;
      for (int j = 0; j < 4; j++) begin
        sum_d[j] = get_word(inData, 2 * j) + get_word(inData, 2 * j + 1);
        rot_d[j] = rotl64(get_word(inData, 2 * j + 1), ROT512[inRound[2:0]][j]);
      end
    end else if (ready_a) begin
      valid_a_d = 1'b0;
    end
  end

  // Stage B next state: finish the MIX with the xor and reassemble the state.
  always_comb begin
    xor_res = '0;
    for (int j = 0; j < 4; j++) begin
      xor_res[word_lsb(2 * j) +: WORD_W]     = sum_q[j];
      xor_res[word_lsb(2 * j + 1) +: WORD_W] = rot_q[j] ^ sum_q[j];
    end
    valid_b_d = valid_b_q;
    data_b_d  = data_b_q;
    round_b_d = round_b_q;
    if (move_ab) begin
      valid_b_d = 1'b1;
      data_b_d  = xor_res;
      round_b_d = round_a_q;
    end else if (outReady) begin
      valid_b_d = 1'b0;
    end
  end

  // Both stage registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_a_q <= 1'b0;
      round_a_q <= '0;
      for (int j = 0; j < 4; j++) begin
        sum_q[j] <= '0;
        rot_q[j] <= '0;
      end
      valid_b_q <= 1'b0;
      data_b_q  <= '0;
      round_b_q <= '0;
    end else begin
      valid_a_q <= valid_a_d;
      round_a_q <= round_a_d;
      sum_q     <= sum_d;
      rot_q     <= rot_d;
      valid_b_q <= valid_b_d;
      data_b_q  <= data_b_d;
      round_b_q <= round_b_d;
    end
  end

  assign outValid = valid_b_q;
  assign outData  = data_b_q;
  assign outRound = round_b_q;

`endif

endmodule

// File: tb/tb_threefish_mix_stage.sv
// Bench for threefish_mix_stage: directed table, stall/stream and reset checks.
`timescale 1ns/1ps
module tb_threefish_mix_stage;

  localparam int RW = 7;
`ifdef THREEFISH_MIX_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int N_STREAM = 40;

  localparam int TB_ROT [8][4] = '{
    '{46, 36, 19, 37}, '{33, 27, 14, 42}, '{17, 49, 36, 39}, '{44, 9, 54, 56},
    '{39, 30, 34, 24}, '{13, 50, 10, 17}, '{25, 29, 39, 43}, '{8, 35, 56, 22}
  };

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           inValid = 1'b0;
  logic           inReady;
  logic [511:0]   inData = '0;
  logic [RW-1:0]  inRound = '0;
  logic           outValid;
  logic           outReady = 1'b0;
  logic [511:0]   outData;
  logic [RW-1:0]  outRound;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [511:0]  data;
    logic [RW-1:0] rnd;
    logic [511:0]  exp;
  } vec_t;

  vec_t tbl[$];
  logic [511:0]  exp_d[$];
  logic [RW-1:0] exp_r[$];

  always #5 clk = ~clk;

  threefish_mix_stage #(.ROUND_W(RW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inValid  (inValid),
    .inReady  (inReady),
    .inData   (inData),
    .inRound  (inRound),
    .outValid (outValid),
    .outReady (outReady),
    .outData  (outData),
    .outRound (outRound)
  );

  function automatic logic [511:0] wset(input logic [511:0] s, input int i, input logic [63:0] w);
    logic [511:0] r;
    r = s;
    r[511 - 64 * i -: 64] = w;
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[32 * k +: 32] = $urandom;
    return r;
  endfunction

  // Reference: four MIX pairs, rotation done on a doubled word.
  function automatic logic [511:0] ref_mix(input logic [511:0] s, input int d);
    logic [511:0] r;
    logic [63:0]  x0, x1, y0, y1;
    logic [127:0] dbl;
    int           sh;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      x0  = s[511 - 128 * j -: 64];
      x1  = s[447 - 128 * j -: 64];
      y0  = x0 + x1;
      sh  = TB_ROT[d % 8][j];
      dbl = {x1, x1};
      y1  = dbl[127 - sh -: 64] ^ y0;
      r[511 - 128 * j -: 64] = y0;
      r[447 - 128 * j -: 64] = y1;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_one(input logic [511:0] d, input logic [RW-1:0] r,
                         input logic [511:0] e, input string nm);
    int cyc;
    @(posedge clk); #1;
    outReady = 1'b1;
    inValid  = 1'b1;
    inData   = d;
    inRound  = r;
    #1 chk({nm, " inReady"}, inReady, 1);
    @(posedge clk); #1;
    inValid = 1'b0;
    inData  = rand512();
    inRound = RW'($urandom);
    cyc = 1;
    while (!outValid && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " latency"}, cyc, LAT);
    chk({nm, " data"}, outData, e);
    chk({nm, " round"}, outRound, r);
    @(posedge clk); #1;
    chk({nm, " drained"}, outValid, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          v;
    logic [511:0]  sv [N_STREAM];
    logic [RW-1:0] sr [N_STREAM];
    logic [511:0]  pd, rv;
    logic [RW-1:0] pr, rr;
    logic          hold, pstall;
    int            sent, recv, cyc;

    // Directed table
    v.data = '0; v.rnd = 0; v.exp = '0;
    tbl.push_back(v);
    v.data = wset('0, 1, 64'h1); v.rnd = 0;
    v.exp  = wset(wset('0, 0, 64'h1), 1, 64'h0000400000000001);
    tbl.push_back(v);
    v.data = wset(wset('0, 0, 64'hFFFFFFFFFFFFFFFF), 1, 64'h1); v.rnd = 0;
    v.exp  = wset('0, 1, 64'h0000400000000000);
    tbl.push_back(v);
    v.data = wset('0, 7, 64'h8000000000000000); v.rnd = 7;
    v.exp  = wset(wset('0, 6, 64'h8000000000000000), 7, 64'h8000000000200000);
    tbl.push_back(v);
    v.rnd = 15;
    tbl.push_back(v);
    for (int k = 0; k < 3; k++) begin
      v.data = rand512();
      v.rnd  = RW'($urandom_range(0, 71));
      v.exp  = ref_mix(v.data, int'(v.rnd));
      tbl.push_back(v);
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset outValid", outValid, 0);
    chk("reset outData", outData, 0);
    chk("reset outRound", outRound, 0);
    chk("reset inReady", inReady, 1);
    rst_n = 1'b1;

    foreach (tbl[i]) run_one(tbl[i].data, tbl[i].rnd, tbl[i].exp, $sformatf("vec%0d", i));

    // Stream with random stalls
    for (int k = 0; k < N_STREAM; k++) begin
      sv[k] = rand512();
      sr[k] = RW'($urandom);
    end
    sent = 0; recv = 0; hold = 1'b0; pstall = 1'b0; pd = '0; pr = '0;
    @(posedge clk); #1;
    for (int c = 0; c < 3000 && recv < N_STREAM; c++) begin
      if (pstall) begin
        chk("stall outValid held", outValid, 1);
        chk("stall outData held", outData, pd);
        chk("stall outRound held", outRound, pr);
      end
      if (!hold) begin
        inValid = (sent < N_STREAM) && ($urandom_range(0, 3) != 0);
        if (inValid) begin
          inData  = sv[sent];
          inRound = sr[sent];
        end else begin
          inData  = rand512();
          inRound = RW'($urandom);
        end
      end
      outReady = ($urandom_range(0, 2) != 0);
      #1;
      if (!inReady) chk("stream inReady low only when stalled", outValid && !outReady, 1);
`ifndef THREEFISH_MIX_PIPE2_EN
      chk("stream inReady", inReady, !(outValid && !outReady));
`endif
      if (outValid && outReady) begin
        if (exp_d.size() == 0) begin
          chk("stream extra output", exp_d.size(), 1);
        end else begin
          chk($sformatf("stream data%0d", recv), outData, exp_d.pop_front());
          chk($sformatf("stream round%0d", recv), outRound, exp_r.pop_front());
        end
        recv++;
      end
      if (inValid && inReady) begin
        exp_d.push_back(ref_mix(sv[sent], int'(sr[sent])));
        exp_r.push_back(sr[sent]);
        sent++;
        hold = 1'b0;
      end else begin
        hold = inValid;
      end
      pstall = outValid && !outReady;
      pd = outData;
      pr = outRound;
      @(posedge clk); #1;
    end
    chk("stream received count", recv, N_STREAM);
    inValid  = 1'b0;
    outReady = 1'b1;
    repeat (LAT + 1) @(posedge clk);
    #1 chk("stream no duplicate", outValid, 0);

    // Reset during a stall
    rv = rand512();
    rr = RW'($urandom);
    @(posedge clk); #1;
    outReady = 1'b0;
    inValid  = 1'b1;
    inData   = rv;
    inRound  = rr;
    @(posedge clk); #1;
    inValid = 1'b0;
    cyc = 1;
    while (!outValid && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("stall latency", cyc, LAT);
    repeat (2) @(posedge clk);
    #1;
    chk("stall pre-reset outValid", outValid, 1);
    chk("stall pre-reset data", outData, ref_mix(rv, int'(rr)));
    chk("stall pre-reset round", outRound, rr);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outValid", outValid, 0);
    chk("async reset outData", outData, 0);
    chk("async reset outRound", outRound, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rv = rand512();
    rr = RW'($urandom);
    run_one(rv, rr, ref_mix(rv, int'(rr)), "post-reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
